// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : rv32_pkg                                                     |
// | Description : Shared constants and types for the rv32 core front end.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rv32_pkg;

  localparam int XLEN = 32;

  // Word PC fetched first after reset.
  localparam logic [XLEN-1:0] RESET_PC = '0;

  // One buffered fetch result: the instruction word and the word PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32_fetch_queue                                             |
// | Description : DEPTH-entry circular FIFO of fetch entries with synchronous  |
// |               flush. Head entry is always visible on head_o.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv32_fetch_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  localparam int c_ptr_w = $clog2(DEPTH);

  fetch_entry_t       mem_q [DEPTH];
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               w_do_push;
  logic               w_do_pop;

  // The producer's credit scheme never pushes into a full queue; the full guard
  // only keeps a stray push from corrupting the head.
  assign w_do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign w_do_pop  = pop_i  && (count_q != '0);

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a push in a flush cycle is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule : rv32_fetch_queue
`default_nettype wire

// File: rtl/rv32_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv32_fetch_stage                                             |
// | Description : Instruction fetch stage. Owns the fetch PC, issues at most   |
// |               one read to a 1-cycle synchronous imem, buffers returned     |
// |               words in a small queue and hands them to decode over a       |
// |               valid/ready handshake. Redirects flush wrong-path work.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv32_fetch_stage
  import rv32_pkg::*;
#(
  parameter int              IMEM_AW  = 10,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = rv32_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,          // asynchronous, active low
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_inst,
  output logic [XLEN-1:0]    out_pc
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic [c_cnt_w-1:0] w_count;
  logic [c_cnt_w:0]   w_occ;
  logic               w_pop;
  logic               w_push;
  fetch_entry_t       w_head;
  fetch_entry_t       w_push_entry;

  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready;

  // Slots already committed after this cycle's pop; a new request is allowed
  // only if its response is guaranteed a free queue entry.
  assign w_occ = {1'b0, w_count}
               + {{c_cnt_w{1'b0}}, inflight_q}
               - {{c_cnt_w{1'b0}}, w_pop};

  // Gated by reset so the strobe is low while reset is held.
  assign imem_req  = reset && !redirect_valid && (w_occ < (c_cnt_w + 1)'(DEPTH));
  assign imem_addr = fetch_pc_q[IMEM_AW-1:0];

  // The response lands the cycle after its request unless a redirect kills it.
  assign w_push       = inflight_q && !redirect_valid;
  assign w_push_entry = '{pc: inflight_pc_q, inst: imem_rdata};

  // Fetch PC / in-flight tracking; redirect overrides any issue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_req) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + XLEN'(1);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  rv32_fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (c_cnt_w)
  ) u_queue (
    .clk          (clk),
    .rst_n        (reset),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop && !redirect_valid),
    .flush_i      (redirect_valid),
    .count_o      (w_count),
    .head_o       (w_head)
  );

  // Present zeros when empty so reset and flush leave clean outputs.
  assign out_inst = out_valid ? w_head.inst : '0;
  assign out_pc   = out_valid ? w_head.pc   : '0;

endmodule : rv32_fetch_stage
`default_nettype wire
